// File: rtl/battleship_nios2_qsys_0_oci_pkg.sv
// Shared widths, counts and the packer state enum for the OCI data-trace path.
// Atoms are 2-bit codes; a full frame carries 15 of them in 30 bits.
package battleship_nios2_qsys_0_oci_pkg;

    localparam int ATOM_W  = 2;
    localparam int ATOMS   = 15;
    localparam int FRAME_W = ATOM_W * ATOMS;
    localparam int CNT_W   = 4;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } state_e;

    // Newest atom lands at the LSB; the oldest atom ends up in the high bits.
    function automatic logic [FRAME_W-1:0] pack_atom(
        input logic [FRAME_W-1:0] acc,
        input logic [ATOM_W-1:0]  a
    );
        return {acc[FRAME_W-ATOM_W-1:0], a};
    endfunction

endpackage

// File: rtl/battleship_nios2_qsys_0_oci_dtrace_frame_reg.sv
// One-entry valid/ready holding register for packed trace frames (data + atom count).
// Load is only issued by the packer while slot_free is high, so a held frame is never overwritten.
module battleship_nios2_qsys_0_oci_dtrace_frame_reg
    import battleship_nios2_qsys_0_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic [CNT_W-1:0]   load_count,
    output logic               slot_free,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic [CNT_W-1:0]   frame_count
);

    logic               valid_q, valid_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // A frame leaving this cycle frees the slot for a same-cycle refill.
    assign slot_free   = !valid_q || frame_ready;
    assign frame_valid = valid_q;
    assign frame_data  = data_q;
    assign frame_count = count_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (valid_q && frame_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/battleship_nios2_qsys_0_oci_dtrace_pack.sv
// Packs 2-bit trace atoms into 30-bit frames and hands them out over valid/ready.
// test_ending drains the partial frame, then test_has_ended latches until reset.
module battleship_nios2_qsys_0_oci_dtrace_pack
    import battleship_nios2_qsys_0_oci_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               atom_valid,
    input  logic [ATOM_W-1:0]  atom,
    output logic               atom_ready,
    input  logic               flush,
    input  logic               test_ending,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic [CNT_W-1:0]   frame_count,
    output logic [FRAME_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               test_has_ended
);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] buf_q, buf_d, buf_acc;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_acc;
    logic               flush_pend_q, flush_pend_d;
    logic               slot_free;
    logic               accept;
    logic               flush_req;
    logic               xfer;

    battleship_nios2_qsys_0_oci_dtrace_frame_reg u_frame_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (xfer),
        .load_data   (buf_acc),
        .load_count  (cnt_acc),
        .slot_free   (slot_free),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_count (frame_count)
    );

    always_comb begin
        atom_ready   = (state_q == FILL) && !((cnt_q == CNT_FULL) && !slot_free);
        accept       = atom_valid && atom_ready;
        buf_acc      = accept ? pack_atom(buf_q, atom) : buf_q;
        cnt_acc      = accept ? cnt_q + CNT_ONE : cnt_q;
        // test_ending acts as a flush in its own cycle; DRAIN keeps flushing until empty.
        flush_req    = (state_q == FILL)  ? (flush || test_ending || flush_pend_q)
                                          : (state_q == DRAIN);
        xfer         = slot_free && (cnt_acc != '0) && ((cnt_acc == CNT_FULL) || flush_req);
        buf_d        = xfer ? '0 : buf_acc;
        cnt_d        = xfer ? '0 : cnt_acc;
        flush_pend_d = (state_q == FILL) && flush_req && !xfer && (cnt_acc != '0);

        state_d = state_q;
        case (state_q)
            FILL: begin
                if (test_ending) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_q == '0) && !frame_valid) begin
                    state_d = ENDED;
                end
            end
            ENDED:   state_d = ENDED;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            buf_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_has_ended = (state_q == ENDED);

endmodule

// File: doc/battleship_nios2_qsys_0_oci_dtrace_pack.md
# battleship_nios2_qsys_0_oci_dtrace_pack

Data-trace packer for the Nios II OCI debug path. Accepts 2-bit trace atoms from the CPU trace tap and packs up to 15 of them into a 30-bit frame. Hands completed frames to the trace FIFO over a valid/ready handshake. Exposes the live accumulator (`dct_buffer`, `dct_count`) and the end-of-test status (`test_has_ended`) to the OCI test bench that sits directly downstream.

## Interface
- `ATOM_W`, 2, bits per trace atom
- `ATOMS`, 15, atoms per full frame; `ATOM_W*ATOMS` = 30
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `atom_valid`  in  1  atom present this cycle
- `atom`  in  2  trace atom code; any value is legal
- `atom_ready`  out  1  packer accepts an atom this cycle
- `flush`  in  1  single-cycle request to emit a partial frame
- `test_ending`  in  1  single-cycle request to drain and stop
- `frame_valid`  out  1  frame slot holds a frame
- `frame_ready`  in  1  downstream takes the frame
- `frame_data`  out  30  packed frame; unused upper bits are 0
- `frame_count`  out  4  atoms in the frame, 1..15
- `dct_buffer`  out  30  live accumulator contents
- `dct_count`  out  4  live accumulator atom count, 0..15
- `test_has_ended`  out  1  sticky; drain is complete

## Operation
- Accept condition: an atom is accepted when `atom_valid && atom_ready`.
- Packing: an accepted atom shifts in at the LSB, so `dct_buffer <= {dct_buffer[27:0], atom}`, and `dct_count` increments.
- Frame slot: a one-entry holding register. It is "free" when `!frame_valid`, or when `frame_valid && frame_ready` in the same cycle.
- Transfer: accumulator contents move to the slot when either of these holds:
  - count reaches 15, including the accepting cycle, so the 15th atom goes straight to the slot;
  - a flush is pending and count > 0.
  
  The transfer happens only if the slot is free. It clears the accumulator to count 0 and buffer 0.
- Blocked full: if count = 15 and the slot is not free, the accumulator holds and `atom_ready` = 0.
- Simultaneous flush and atom: the atom is included in the flushed frame.
- Pending flush: a flush with count 0 is a no-op. A flush that cannot transfer stays pending until the slot frees.
- State machine:
  - FILL: normal operation. `test_ending` moves to DRAIN and sets an internal flush.
  - DRAIN: `atom_ready` = 0. Transfer the accumulator if non-empty. When the accumulator is empty and `frame_valid` = 0, move to ENDED.
  - ENDED: `test_has_ended` = 1, `atom_ready` = 0. Leave only by reset.
- `atom_ready` = (state == FILL) && !(count == 15 && slot not free).

## Timing
- Reset values: `atom_ready` = 1, `frame_valid` = 0, `frame_data` = 0, `frame_count` = 0, `dct_buffer` = 0, `dct_count` = 0, `test_has_ended` = 0, state = FILL, pending flush cleared.
- Reset mid-operation: discards the partial accumulator and any held frame without emitting them.
- Latency: the 15th accepted atom in cycle N gives `frame_valid` = 1 in cycle N+1. A flush in cycle N (slot free) gives `frame_valid` in cycle N+1.
- Handshake: `frame_data` and `frame_count` stay stable while `frame_valid && !frame_ready`. Back-to-back frames are allowed, one per cycle at best.
- Drain timing: `test_ending` in cycle N with an empty accumulator and empty slot gives `test_has_ended` = 1 in cycle N+2 (DRAIN for one cycle).
- Output timing: `dct_buffer` and `dct_count` are registered and reflect the state after the previous edge.

## Structure
- Shared package `battleship_nios2_qsys_0_oci_pkg` holds:
  - `ATOM_W`, `ATOMS`, frame width 30, count width 4;
  - the state enum {FILL, DRAIN, ENDED}.
- Sub-module `battleship_nios2_qsys_0_oci_dtrace_frame_reg`: the one-entry valid/ready holding register (30+4 bits).

## Test plan
- Reset, then 15 atoms 0,1,2,3,0,… with `frame_ready` = 1 → one frame with `frame_count` = 15, `frame_data` = 30'h06C6C6C6 (pattern check), then `dct_count` = 0.
- 5 atoms of 2'b11, then `flush` → `frame_count` = 5, `frame_data` = 30'h000003FF, `frame_valid` one cycle after the flush.
- `frame_ready` held 0, 30 atoms streamed → first frame held stable, accumulator reaches 15, `atom_ready` drops. Raising `frame_ready` then yields the two frames on consecutive cycles.
- 3 atoms, then `test_ending` → partial frame (count 3) emitted, `atom_ready` = 0 from the next cycle, `test_has_ended` rises after the frame is taken and stays high.
- Reset asserted with a held frame and count 7 → all outputs return to their reset values the next cycle, with no frame emitted.
- Flush and atom in the same cycle with count 14 → single frame with count 15, no empty frame after it.
